// File: rtl/motor_phase_pkg.sv
// Shared constants, phase-code helpers and FSM state encoding for the
// stepper phase decoder.
package motor_phase_pkg;

  localparam logic [3:0] PH_0 = 4'b1001;
  localparam logic [3:0] PH_1 = 4'b1010;
  localparam logic [3:0] PH_2 = 4'b0110;
  localparam logic [3:0] PH_3 = 4'b0101;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } state_e;

  function automatic logic code_valid(input logic [3:0] code);
    return (code == PH_0) || (code == PH_1) || (code == PH_2) || (code == PH_3);
  endfunction

  function automatic logic [1:0] code_to_idx(input logic [3:0] code);
    logic [1:0] idx;
    case (code)
      PH_1:    idx = 2'd1;
      PH_2:    idx = 2'd2;
      PH_3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/motor_phase_if.sv
// Signal bundle between the phase decoder and its observer, plus FSM debug state.
interface motor_phase_if
  #(parameter int POS_W = 16,
    parameter int PER_W = 24);
  import motor_phase_pkg::*;

  // No valid/ready pair here: STEP_PULSE is a one-cycle strobe that marks the
  // cycle in which POS, DIR and STEP_PERIOD take their new values; all other
  // outputs are level signals valid every cycle.
  logic [3:0]       PHASE_IN;
  logic             CLR;
  logic             STEP_PULSE;
  logic             DIR;
  logic [POS_W-1:0] POS;
  logic [PER_W-1:0] STEP_PERIOD;
  logic             RUNNING;
  logic             SYNCED;
  logic             ERR_FLAG;
  logic [7:0]       ERR_CNT;
  state_e           STATE;

  modport master (
    output PHASE_IN, CLR,
    input  STEP_PULSE, DIR, POS, STEP_PERIOD, RUNNING, SYNCED, ERR_FLAG, ERR_CNT, STATE
  );

  modport slave (
    input  PHASE_IN, CLR,
    output STEP_PULSE, DIR, POS, STEP_PERIOD, RUNNING, SYNCED, ERR_FLAG, ERR_CNT, STATE
  );

endinterface

// File: rtl/phase_glitch_filter.sv
// Registers the coil pattern and emits a one-cycle accept strobe once a code
// different from the last accepted one has been stable for FILT_CYCLES samples.
module phase_glitch_filter #(
  parameter int FILT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] phase_i,
  output logic [3:0] code_o,
  output logic       accept_o
);

  localparam int             CW      = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CYCLES);

  logic [3:0]    in_q, cand_q, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_q, accept_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_q != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Comparing against the accepted code keeps a held input from re-firing.
    accept_d = (cnt_d == CNT_MAX) && (in_q != acc_q);
    acc_d    = accept_d ? in_q : acc_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      in_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      in_q     <= phase_i;
      cand_q   <= in_q;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      accept_q <= accept_d;
    end
  end

  assign code_o   = acc_q;
  assign accept_o = accept_q;

endmodule

// File: rtl/motor_phase_decoder.sv
// Decodes filtered stepper phase codes into step pulses, direction, signed
// position, step period, running/synced status and sequence-error tracking.
module motor_phase_decoder
  import motor_phase_pkg::*;
#(
  parameter int FILT_CYCLES = 16,
  parameter int TIMEOUT     = 1000000,
  parameter int POS_W       = 16,
  parameter int PER_W       = 24
) (
  input  logic         CLK,
  input  logic         RESET,
  motor_phase_if.slave bus
);

  localparam logic [PER_W-1:0] GAP_MAX = '1;
  localparam logic [PER_W-1:0] TO_M1   = PER_W'(TIMEOUT - 1);

  logic [3:0] code;
  logic       accept;

  phase_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filter (
    .CLK      (CLK),
    .RESET    (RESET),
    .phase_i  (bus.PHASE_IN),
    .code_o   (code),
    .accept_o (accept)
  );

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d, new_idx, diff;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PER_W-1:0] gap_q, gap_d, per_q, per_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             pulse_q, pulse_d, dir_q, dir_d, run_q, run_d;
  logic             sync_q, sync_d, eflag_q, eflag_d, err;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    per_d   = per_q;
    ecnt_d  = ecnt_q;
    pulse_d = 1'b0;
    dir_d   = dir_q;
    run_d   = run_q;
    sync_d  = sync_q;
    eflag_d = eflag_q;
    err     = 1'b0;
    new_idx = code_to_idx(code);
    diff    = new_idx - idx_q;
    gap_d   = (gap_q == GAP_MAX) ? gap_q : gap_q + PER_W'(1);

    if (gap_q >= TO_M1) run_d = 1'b0;

    if (accept) begin
      gap_d = '0;
      case (state_q)
        ST_INIT, ST_LOST: begin
          if (code_valid(code)) begin
            idx_d   = new_idx;
            sync_d  = 1'b1;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!code_valid(code)) begin
            err     = 1'b1;
            sync_d  = 1'b0;
            run_d   = 1'b0;
            state_d = ST_LOST;
          end else if (diff == 2'd2) begin
            err   = 1'b1;
            idx_d = new_idx;
          end else if (diff != 2'd0) begin
            pulse_d = 1'b1;
            dir_d   = (diff == 2'd3);
            pos_d   = (diff == 2'd1) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            per_d   = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + PER_W'(1);
            run_d   = 1'b1;
            idx_d   = new_idx;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    if (err) begin
      eflag_d = 1'b1;
      if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    end

    // Clear dominates only the accumulated values; the step itself still shows.
    if (bus.CLR) begin
      pos_d   = '0;
      ecnt_d  = '0;
      eflag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      pos_q   <= '0;
      gap_q   <= '0;
      per_q   <= '0;
      ecnt_q  <= '0;
      pulse_q <= 1'b0;
      dir_q   <= 1'b0;
      run_q   <= 1'b0;
      sync_q  <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      gap_q   <= gap_d;
      per_q   <= per_d;
      ecnt_q  <= ecnt_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      sync_q  <= sync_d;
      eflag_q <= eflag_d;
    end
  end

  assign bus.STEP_PULSE  = pulse_q;
  assign bus.DIR         = dir_q;
  assign bus.POS         = pos_q;
  assign bus.STEP_PERIOD = per_q;
  assign bus.RUNNING     = run_q;
  assign bus.SYNCED      = sync_q;
  assign bus.ERR_FLAG    = eflag_q;
  assign bus.ERR_CNT     = ecnt_q;
  assign bus.STATE       = state_q;

endmodule
